key_text_buffer: RTL and testbench

- Sits between keyboard_controller and display in the slow_clk domain.
- Turns the raw level pair (key_code, key_pressed) into debounced, one-per-press key events.
- Applies editing commands (character, backspace, clear) to a line buffer of DEPTH characters.
- Presents the most recent WINDOW characters as a right-aligned window, blank-padded on the left, ready for the display stage.

---
 rtl/typewriter_pkg.sv | 25 ++
 rtl/key_text_buffer_if.sv | 28 ++
 rtl/key_text_buffer_debouncer.sv | 96 +++++++++
 rtl/key_text_buffer.sv | 86 ++++++++
 tb/tb_key_text_buffer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/typewriter_pkg.sv
// Shared types and key-code constants for the keyboard-to-display path.
// No logic and no latency; there is no flow control at this level.
// Used by the debouncer, the text buffer and its interface.
package typewriter_pkg;

    typedef logic [4:0] code_t;

    localparam code_t CHAR_BLANK    = 5'h1F;
    localparam code_t KEY_BKSP      = 5'h0E;
    localparam code_t KEY_CLEAR     = 5'h0F;
    localparam code_t KEY_LAST_CHAR = 5'h0D;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } db_state_t;

    // Codes above CLEAR are debounced like any other key but carry no command.
    function automatic logic is_ignored(code_t c);
        return c > KEY_CLEAR;
    endfunction

endpackage

// File: rtl/key_text_buffer_if.sv
// Key input levels plus the window, count and event outputs of the text buffer.
// Purely wires; no latency.
// No backpressure: the display side samples these outputs every clk cycle.
interface key_text_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int WINDOW = 4
);
    import typewriter_pkg::*;

    code_t                      key_code;
    logic                       key_pressed;
    logic [5*WINDOW-1:0]        window_chars;
    logic [$clog2(DEPTH+1)-1:0] char_count;
    logic                       buf_full;
    logic                       key_event;
    logic                       overflow;

    modport master (
        output key_code, key_pressed,
        input  window_chars, char_count, buf_full, key_event, overflow
    );

    modport slave (
        input  key_code, key_pressed,
        output window_chars, char_count, buf_full, key_event, overflow
    );

endinterface

// File: rtl/key_text_buffer_debouncer.sv
// Debounces the raw (key_code, key_pressed) levels into one event per press.
// event_valid is combinational, high during the sample that completes debounce.
// No backpressure: an event must be consumed in the cycle it is offered.
module key_debouncer
    import typewriter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  code_t key_code,
    input  logic  key_pressed,
    output logic  event_valid,
    output code_t event_code
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    db_state_t     state, state_nxt;
    code_t         cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (key_pressed) begin
                    cand_nxt  = key_code;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (CNT_ONE == CNT_DONE) ? HELD : PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!key_pressed) begin
                    state_nxt = IDLE;
                end else if (key_code != cand) begin
                    cand_nxt = key_code;
                    cnt_nxt  = CNT_ONE;
                    if (CNT_ONE == CNT_DONE) state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_DONE) state_nxt = HELD;
                end
            end
            HELD: begin
                // Code changes while held are deliberately not looked at: no auto-repeat.
                if (!key_pressed) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (CNT_ONE == CNT_DONE) ? IDLE : RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (key_pressed) begin
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_DONE) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On acceptance cand always equals the live key_code, so forward the input.
    always_comb begin
        event_valid = 1'b0;
        event_code  = key_code;
        case (state)
            IDLE:     event_valid = key_pressed && (CNT_ONE == CNT_DONE);
            PRESS_DB: event_valid = key_pressed &&
                                    ((key_code != cand) ? (CNT_ONE == CNT_DONE)
                                                        : (cnt_inc == CNT_DONE));
            default:  event_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_text_buffer.sv
// Debounced key events edit a DEPTH-char line; newest WINDOW chars go to display.
// Buffer update and key_event appear one cycle after the completing sample.
// No backpressure: characters typed into a full buffer are dropped with overflow.
module key_text_buffer
    import typewriter_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int WINDOW          = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    key_text_buffer_if.slave  bus
);

    localparam int CNTW = $clog2(DEPTH + 1);

    code_t               ent [DEPTH];
    logic [CNTW-1:0]     count;
    logic                key_event_q;
    logic                overflow_q;
    logic                ev_vld;
    code_t               ev_code;
    logic                accept;
    logic [5*WINDOW-1:0] window;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .key_code    (bus.key_code),
        .key_pressed (bus.key_pressed),
        .event_valid (ev_vld),
        .event_code  (ev_code)
    );

    assign accept = ev_vld && !is_ignored(ev_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= CHAR_BLANK;
            count       <= '0;
            key_event_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            key_event_q <= accept;
            overflow_q  <= 1'b0;
            if (accept) begin
                if (ev_code <= KEY_LAST_CHAR) begin
                    if (count != CNTW'(DEPTH)) begin
                        for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
                        ent[0] <= ev_code;
                        count  <= count + 1'b1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else if (ev_code == KEY_BKSP) begin
                    if (count != '0) begin
                        for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
                        ent[DEPTH-1] <= CHAR_BLANK;
                        count        <= count - 1'b1;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) ent[i] <= CHAR_BLANK;
                    count <= '0;
                end
            end
        end
    end

    // Right-aligned window: slot 0 is the newest character.
    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW; i++) begin
            window[5*i +: 5] = (CNTW'(i) < count) ? ent[i] : CHAR_BLANK;
        end
    end

    assign bus.window_chars = window;
    assign bus.char_count   = count;
    assign bus.buf_full     = (count == CNTW'(DEPTH));
    assign bus.key_event    = key_event_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_key_text_buffer.sv
// Scoreboarded bench for key_text_buffer: expected post-event state is queued
// when a press is driven and checked by a monitor whenever key_event fires.
module tb_key_text_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_text_buffer_if #(.DEPTH(8), .WINDOW(4)) bus ();

    key_text_buffer #(
        .DEPTH           (8),
        .WINDOW          (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [19:0] win;
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] model[$];
    exp_t       e_mon;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [19:0] model_win();
        logic [19:0] w;
        for (int i = 0; i < 4; i++) w[5*i +: 5] = (i < model.size()) ? model[i] : 5'h1F;
        return w;
    endfunction

    task automatic cyc(input logic kp, input logic [4:0] code);
        bus.key_pressed = kp;
        bus.key_code    = code;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic [4:0] code);
        exp_t e;
        e.ovf = 1'b0;
        if (code <= 5'h0D) begin
            if (model.size() < 8) model.push_front(code);
            else e.ovf = 1'b1;
        end else if (code == 5'h0E) begin
            if (model.size() > 0) void'(model.pop_front());
        end else begin
            model.delete();
        end
        e.win = model_win();
        e.cnt = 4'(model.size());
        sb.push_back(e);
    endtask

    task automatic press(input logic [4:0] code);
        if (code <= 5'h0F) expect_event(code);
        repeat (3) cyc(1'b1, code);
        repeat (3) cyc(1'b0, code);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_event code=%h pending=%0d required=0", code, sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.key_event) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event win=%h cnt=%0d", bus.window_chars, bus.char_count);
            end else begin
                e_mon = sb.pop_front();
                if (bus.window_chars !== e_mon.win || bus.char_count !== e_mon.cnt ||
                    bus.overflow !== e_mon.ovf) begin
                    errors++;
                    $display("FAIL event_state win=%h cnt=%0d ovf=%b required win=%h cnt=%0d ovf=%b",
                             bus.window_chars, bus.char_count, bus.overflow,
                             e_mon.win, e_mon.cnt, e_mon.ovf);
                end
            end
        end else if (!rst && bus.overflow) begin
            errors++;
            $display("FAIL stray_overflow overflow=%b required=0", bus.overflow);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 5'h00);
        cyc(1'b0, 5'h00);
        rst = 1'b0;
        checks++;
        if (bus.char_count !== 4'd0 || bus.window_chars !== 20'hFFFFF || bus.buf_full !== 1'b0 ||
            bus.key_event !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cnt=%0d win=%h full=%b ev=%b ovf=%b required 0 fffff 0 0 0",
                     bus.char_count, bus.window_chars, bus.buf_full, bus.key_event, bus.overflow);
        end
    endtask

    task automatic test_single();
        expect_event(5'h05);
        cyc(1'b1, 5'h05);
        cyc(1'b1, 5'h05);
        checks++;
        if (bus.key_event !== 1'b0) begin
            errors++;
            $display("FAIL early_event key_event=%b required=0", bus.key_event);
        end
        cyc(1'b1, 5'h05);
        checks++;
        if (bus.key_event !== 1'b1) begin
            errors++;
            $display("FAIL event_latency key_event=%b required=1", bus.key_event);
        end
        repeat (3) cyc(1'b0, 5'h05);
        checks++;
        if (bus.window_chars !== 20'hFFFE5 || bus.char_count !== 4'd1) begin
            errors++;
            $display("FAIL single_char win=%h cnt=%0d required win=fffe5 cnt=1",
                     bus.window_chars, bus.char_count);
        end
    endtask

    task automatic test_bounce();
        expect_event(5'h02);
        cyc(1'b1, 5'h02);
        cyc(1'b0, 5'h02);
        cyc(1'b1, 5'h02);
        cyc(1'b1, 5'h02);
        checks++;
        if (bus.key_event !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early key_event=%b required=0", bus.key_event);
        end
        cyc(1'b1, 5'h02);
        checks++;
        if (bus.key_event !== 1'b1) begin
            errors++;
            $display("FAIL bounce_accept key_event=%b required=1", bus.key_event);
        end
        cyc(1'b1, 5'h02);
        cyc(1'b0, 5'h02);
        cyc(1'b1, 5'h02);
        cyc(1'b1, 5'h07);
        repeat (3) cyc(1'b0, 5'h02);
        checks++;
        if (bus.char_count !== 4'd2 || bus.window_chars !== model_win()) begin
            errors++;
            $display("FAIL release_glitch cnt=%0d win=%h required cnt=2 win=%h",
                     bus.char_count, bus.window_chars, model_win());
        end
    endtask

    task automatic test_type_backspace();
        press(5'h0F);
        for (int k = 1; k <= 5; k++) press(5'(k));
        checks++;
        if (bus.window_chars !== 20'h10C85 || bus.char_count !== 4'd5) begin
            errors++;
            $display("FAIL type_five win=%h cnt=%0d required win=10c85 cnt=5",
                     bus.window_chars, bus.char_count);
        end
        press(5'h0E);
        checks++;
        if (bus.window_chars !== 20'h08864 || bus.char_count !== 4'd4) begin
            errors++;
            $display("FAIL backspace win=%h cnt=%0d required win=08864 cnt=4",
                     bus.window_chars, bus.char_count);
        end
    endtask

    task automatic test_overflow();
        for (int k = 6; k <= 9; k++) press(5'(k));
        checks++;
        if (bus.char_count !== 4'd8 || bus.buf_full !== 1'b1 || bus.window_chars !== 20'h31D09) begin
            errors++;
            $display("FAIL fill cnt=%0d full=%b win=%h required cnt=8 full=1 win=31d09",
                     bus.char_count, bus.buf_full, bus.window_chars);
        end
        expect_event(5'h0A);
        repeat (3) cyc(1'b1, 5'h0A);
        checks++;
        if (bus.overflow !== 1'b1 || bus.key_event !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pulse ovf=%b ev=%b required 1 1", bus.overflow, bus.key_event);
        end
        repeat (3) cyc(1'b0, 5'h0A);
        checks++;
        if (bus.char_count !== 4'd8 || bus.buf_full !== 1'b1 || bus.window_chars !== 20'h31D09) begin
            errors++;
            $display("FAIL overflow_hold cnt=%0d full=%b win=%h required cnt=8 full=1 win=31d09",
                     bus.char_count, bus.buf_full, bus.window_chars);
        end
    endtask

    task automatic test_clear_empty();
        press(5'h0F);
        checks++;
        if (bus.char_count !== 4'd0 || bus.window_chars !== 20'hFFFFF || bus.buf_full !== 1'b0) begin
            errors++;
            $display("FAIL clear cnt=%0d win=%h full=%b required 0 fffff 0",
                     bus.char_count, bus.window_chars, bus.buf_full);
        end
        press(5'h0E);
        press(5'h12);
        checks++;
        if (bus.char_count !== 4'd0 || bus.window_chars !== 20'hFFFFF) begin
            errors++;
            $display("FAIL empty_ignored cnt=%0d win=%h required 0 fffff",
                     bus.char_count, bus.window_chars);
        end
    endtask

    task automatic test_rst_mid_debounce();
        press(5'h03);
        cyc(1'b1, 5'h05);
        cyc(1'b1, 5'h05);
        rst = 1'b1;
        cyc(1'b1, 5'h05);
        rst = 1'b0;
        model.delete();
        checks++;
        if (bus.char_count !== 4'd0 || bus.window_chars !== 20'hFFFFF || bus.key_event !== 1'b0 ||
            bus.buf_full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid cnt=%0d win=%h ev=%b full=%b ovf=%b required 0 fffff 0 0 0",
                     bus.char_count, bus.window_chars, bus.key_event, bus.buf_full, bus.overflow);
        end
        expect_event(5'h05);
        cyc(1'b1, 5'h05);
        cyc(1'b1, 5'h05);
        checks++;
        if (bus.key_event !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh_early key_event=%b required=0", bus.key_event);
        end
        cyc(1'b1, 5'h05);
        checks++;
        if (bus.key_event !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_accept key_event=%b required=1", bus.key_event);
        end
        repeat (3) cyc(1'b0, 5'h05);
        checks++;
        if (bus.char_count !== 4'd1 || bus.window_chars !== 20'hFFFE5) begin
            errors++;
            $display("FAIL rst_after cnt=%0d win=%h required cnt=1 win=fffe5",
                     bus.char_count, bus.window_chars);
        end
    endtask

    initial begin
        bus.key_pressed = 1'b0;
        bus.key_code    = 5'h00;
        test_reset();
        test_single();
        test_bounce();
        test_type_backspace();
        test_overflow();
        test_clear_empty();
        test_rst_mid_debounce();
        repeat (4) cyc(1'b0, 5'h00);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
